// File: rtl/frac_lut.sv
// Fracturable K-input LUT: one K-input table or two (K-1)-input tables sharing the low
// address bits, configured through a daisy-chainable word shift chain with a mode word.
module frac_lut #(
   parameter int INPUTS       = 4,
   parameter int MEM_SIZE     = 2 ** INPUTS,
   parameter int CONFIG_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [INPUTS-1:0]       addr,
   output logic                    out0,
   output logic                    out1,
   input  logic                    config_en,
   input  logic [CONFIG_WIDTH-1:0] config_in,
   output logic [CONFIG_WIDTH-1:0] config_out,
   output logic                    config_done
);

   localparam int NUM_WORDS = MEM_SIZE / CONFIG_WIDTH + 1;
   localparam int CNT_W     = $clog2(NUM_WORDS + 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_WORDS);

   logic [CONFIG_WIDTH-1:0] r_words [NUM_WORDS];
   logic [CNT_W-1:0]        r_count;
   logic                    r_q0;
   logic                    r_q1;

   logic [MEM_SIZE-1:0]     w_mem;
   logic [INPUTS-2:0]       w_low;
   logic                    w_frac_en;
   logic                    w_reg0;
   logic                    w_reg1;
   logic                    w_done;
   logic                    w_active;
   logic                    w_c0;
   logic                    w_c1;

   // NOTE: the chain storage is reset like any other register, because config_out must read 0
   // straight after reset rather than whatever the flops powered up with.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_WORDS; i++) r_words[i] <= '0;
      end else if (config_en) begin
         r_words[0] <= config_in;
         for (int i = 1; i < NUM_WORDS; i++) r_words[i] <= r_words[i-1];
      end
   end

   // Counter saturates so extra words pass straight through to downstream LUTs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (config_en && (r_count != FULL)) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned
   // and no latch is inferred.
   always_comb begin
      w_mem = '0;
      for (int j = 0; j < NUM_WORDS - 1; j++) w_mem[j*CONFIG_WIDTH +: CONFIG_WIDTH] = r_words[j];
   end

   assign w_frac_en = r_words[NUM_WORDS-1][0];
   assign w_reg0    = r_words[NUM_WORDS-1][1];
   assign w_reg1    = r_words[NUM_WORDS-1][2];
   assign w_low     = addr[INPUTS-2:0];
   assign w_done    = (r_count == FULL);
   assign w_active  = w_done & ~config_en;

   always_comb begin
      w_c0 = w_mem[addr];
      w_c1 = 1'b0;
      if (w_frac_en) begin
         w_c0 = w_mem[{1'b0, w_low}];
         w_c1 = w_mem[{1'b1, w_low}];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q0 <= 1'b0;
         r_q1 <= 1'b0;
      end else if (w_active) begin
         r_q0 <= w_c0;
         r_q1 <= w_c1;
      end
   end

   assign out0        = w_active & (w_reg0 ? r_q0 : w_c0);
   assign out1        = w_active & (w_reg1 ? r_q1 : w_c1);
   assign config_out  = r_words[NUM_WORDS-1];
   assign config_done = w_done;

endmodule

// File: tb/tb_frac_lut.sv
// Scoreboard bench for frac_lut: the driver predicts each cycle's outputs from a queue-based
// model of the chain and table; a negedge monitor pops and compares.
module tb_frac_lut;

   localparam int K  = 4;
   localparam int CW = 8;
   localparam int MS = 2 ** K;
   localparam int NW = MS / CW + 1;

   typedef struct {
      string      tag;
      logic       o0;
      logic       o1;
      logic [7:0] cfg;
      logic       done;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [K-1:0]  addr;
   logic          out0, out1;
   logic          config_en;
   logic [CW-1:0] config_in;
   logic [CW-1:0] config_out;
   logic          config_done;

   int n_checks = 0;
   int n_errors = 0;

   exp_t exp_q[$];

   // Reference model state
   logic [CW-1:0] m_chain[$];
   int            m_count;
   logic          m_q0, m_q1;
   string         m_tag;

   frac_lut #(.INPUTS(K), .CONFIG_WIDTH(CW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .addr        (addr),
      .out0        (out0),
      .out1        (out1),
      .config_en   (config_en),
      .config_in   (config_in),
      .config_out  (config_out),
      .config_done (config_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic mem_bit(input int idx);
      logic [CW-1:0] w;
      w = m_chain[idx / CW];
      return w[idx % CW];
   endfunction

   function automatic void model_lookup(input logic [K-1:0] a, output logic c0, output logic c1);
      logic [CW-1:0] mode;
      int low;
      mode = m_chain[NW-1];
      low  = int'(a) % (MS / 2);
      if (mode[0]) begin
         c0 = mem_bit(low);
         c1 = mem_bit(low + MS / 2);
      end else begin
         c0 = mem_bit(int'(a));
         c1 = 1'b0;
      end
   endfunction

   function automatic void model_reset();
      m_chain.delete();
      for (int i = 0; i < NW; i++) m_chain.push_back('0);
      m_count = 0;
      m_q0    = 1'b0;
      m_q1    = 1'b0;
   endfunction

   // Apply one rising edge to the model using the inputs currently driven.
   function automatic void model_edge();
      logic c0, c1;
      logic act;
      act = (m_count == NW) && !config_en;
      model_lookup(addr, c0, c1);
      if (config_en) begin
         m_chain.push_front(config_in);
         void'(m_chain.pop_back());
         if (m_count < NW) m_count++;
      end else if (act) begin
         m_q0 = c0;
         m_q1 = c1;
      end
   endfunction

   function automatic void push_expect();
      exp_t e;
      logic c0, c1, act;
      logic [CW-1:0] mode;
      mode = m_chain[NW-1];
      act  = (m_count == NW) && !config_en;
      model_lookup(addr, c0, c1);
      e.tag  = m_tag;
      e.o0   = act && (mode[1] ? m_q0 : c0);
      e.o1   = act && (mode[2] ? m_q1 : c1);
      e.cfg  = m_chain[NW-1];
      e.done = (m_count == NW);
      exp_q.push_back(e);
   endfunction

   task automatic step(input logic en, input logic [CW-1:0] din, input logic [K-1:0] a);
      @(posedge clk);
      model_edge();
      #1;
      config_en = en;
      config_in = din;
      addr      = a;
      push_expect();
   endtask

   task automatic load3(input logic [CW-1:0] w0, input logic [CW-1:0] w1, input logic [CW-1:0] w2);
      step(1'b1, w0, addr);
      step(1'b1, w1, addr);
      step(1'b1, w2, addr);
      step(1'b0, 8'h00, addr);
   endtask

   task automatic reset_pulse();
      @(posedge clk);
      model_edge();
      #1;
      rst_n     = 1'b0;
      config_en = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check({e.tag, " out0"}, 32'(out0), 32'(e.o0));
         check({e.tag, " out1"}, 32'(out1), 32'(e.o1));
         check({e.tag, " config_out"}, 32'(config_out), 32'(e.cfg));
         check({e.tag, " config_done"}, 32'(config_done), 32'(e.done));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      config_en = 1'b0;
      config_in = '0;
      addr      = '0;
      model_reset();
      m_tag = "reset";
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      push_expect();
      for (int a = 0; a < MS; a++) step(1'b0, 8'h00, K'(a));

      m_tag = "plain";
      load3(8'h00, 8'h12, 8'h34);
      step(1'b0, 8'h00, 4'd2);
      step(1'b0, 8'h00, 4'd0);
      step(1'b0, 8'h00, 4'd12);

      m_tag = "frac";
      load3(8'h01, 8'hFF, 8'h00);
      for (int a = 0; a < MS; a++) step(1'b0, 8'h00, K'(a));
      step(1'b0, 8'h00, 4'd5);
      step(1'b0, 8'h00, 4'd13);

      m_tag = "reg0";
      load3(8'h02, 8'h00, 8'h0F);
      step(1'b0, 8'h00, 4'd1);
      step(1'b0, 8'h00, 4'd8);
      step(1'b0, 8'h00, 4'd8);

      m_tag = "passthru";
      load3(8'h02, 8'hAA, 8'h55);
      step(1'b1, 8'h77, 4'd3);
      step(1'b0, 8'h00, 4'd3);
      step(1'b0, 8'h00, 4'd4);

      m_tag = "midreset";
      step(1'b1, 8'h01, addr);
      step(1'b1, 8'h22, addr);
      reset_pulse();
      push_expect();
      load3(8'h00, 8'h00, 8'h01);
      step(1'b0, 8'h00, 4'd0);
      step(1'b0, 8'h00, 4'd1);

      m_tag = "random";
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 99) == 0) begin
            reset_pulse();
            push_expect();
         end else begin
            step(($urandom_range(0, 3) == 0), CW'($urandom), K'($urandom));
         end
      end

      @(negedge clk);
      #1;
      m_tag = "drain";
      check("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/frac_lut.md
Name: frac_lut

Overview:
- Next-generation LUT for the CLB: K-input table that can also split into two (K-1)-input LUTs sharing the low address bits.
- Each output has a selectable output register.
- Configured through a daisy-chainable word-stream shift chain that carries a mode word with the table bits.
- A load counter flags when configuration is complete; outputs are gated until then.

Parameters:
- INPUTS, 4, LUT input count K (>=2).
- MEM_SIZE, 2**INPUTS, truth-table bits; must be a multiple of CONFIG_WIDTH.
- CONFIG_WIDTH, 8, configuration word width (>=3).
- NUM_WORDS, MEM_SIZE/CONFIG_WIDTH+1, chain length in words (derived localparam, not overridable).

Ports:
- clk  input  1  single clock for configuration and user logic.
- rst_n  input  1  asynchronous active-low reset.
- addr  input  INPUTS  LUT address.
- out0  output  1  primary LUT output.
- out1  output  1  secondary output; valid only in fractured mode.
- config_en  input  1  shift enable for the configuration chain.
- config_in  input  CONFIG_WIDTH  configuration word in.
- config_out  output  CONFIG_WIDTH  configuration word out, to the next LUT in the chain.
- config_done  output  1  full chain loaded since reset.

Behaviour:
- Reset (async assert, sync release): all chain words = 0, load counter = 0, both output flops = 0. Therefore config_out = 0, config_done = 0, out0 = out1 = 0.
- Chain: words W[0..NUM_WORDS-1].
  - When config_en is high at a clk edge: W[0] <= config_in and W[i] <= W[i-1].
  - config_out = W[NUM_WORDS-1], registered, so there is NUM_WORDS cycles of latency in to out.
- Mapping:
  - W[NUM_WORDS-1] is the mode word, so the first word sent of a NUM_WORDS-word load lands there.
  - W[j] for j < NUM_WORDS-1 holds mem[(j+1)*CONFIG_WIDTH-1 : j*CONFIG_WIDTH]. The last word sent is mem[CONFIG_WIDTH-1:0].
- Mode word bits:
  - bit0 frac_en.
  - bit1 reg0, which selects the registered out0.
  - bit2 reg1, which selects the registered out1.
  - Remaining bits are reserved: stored and shifted, no function.
- Load counter: increments on each config_en cycle and saturates at NUM_WORDS. config_done = (count == NUM_WORDS), registered, and rises the edge after the NUM_WORDS-th word.
- Post-done config_en: the chain keeps shifting (pass-through for downstream LUTs) and the counter stays saturated. The table contents change accordingly; the user is responsible for sending the correct total.
- Combinational lookup:
  - frac_en = 0: c0 = mem[addr], c1 = 0.
  - frac_en = 1: c0 = mem[{1'b0, addr[INPUTS-2:0]}], c1 = mem[{1'b1, addr[INPUTS-2:0]}]. addr[INPUTS-1] is ignored.
- Gating: active = config_done & ~config_en. When active = 0, both output flops hold and out0/out1 are driven 0.
- Output flops: q0 <= c0 and q1 <= c1 on each clk edge while active.
- Output select: out0 = active & (reg0 ? q0 : c0); out1 = active & (reg1 ? q1 : c1).
- Registered path latency: 1 cycle from addr. On the first active cycle after load, the flop holds its pre-load value (0 after reset).
- Reset mid-load: the partial load is discarded; the counter returns to 0 and the next load restarts from word 1.
- Simultaneous config_en and addr change: config_en has priority, so outputs are 0 and flops hold.

Test Plan (INPUTS=4, CONFIG_WIDTH=8, NUM_WORDS=3):
- Reset: rst_n=0, then release -> config_out=0x00, config_done=0, out0=out1=0; addr sweep 0..15 keeps the outputs at 0.
- Plain LUT load:
  - Stimulus: send 0x00, 0x12, 0x34 on config_en.
  - config_done rises the edge after word 3.
  - addr=2 -> out0=1 (0x34 bit2); addr=0 -> out0=0; addr=12 -> out0=1 (0x12 bit4); out1=0 throughout.
- Fractured mode:
  - Stimulus: send 0x01, 0xFF, 0x00.
  - For every addr: out0=0 and out1=1.
  - Toggling addr[3] leaves both outputs unchanged.
- Registered out0:
  - Stimulus: send 0x02, 0x00, 0x0F.
  - addr=1 at cycle n then addr=8 at n+1 -> out0=1 at n+1, 0 at n+2.
  - First active cycle shows out0=0.
- Pass-through:
  - Stimulus: after a full load of 0x02, 0xAA, 0x55, send 0x77 with config_en.
  - During the shift, config_out=0x02.
  - After the shift: config_out=0xAA, config_done stays 1, outputs are 0 while config_en=1 and resume after config_en drops.
- Reset mid-load:
  - Stimulus: send 0x01, 0x22, assert rst_n=0 for one cycle, then send 0x00, 0x00, 0x01.
  - config_done=0 until the third post-reset word; then addr=0 -> out0=1, out1=0.
